// File: rtl/hamming_secded_dec_if.sv
// ---------------------------------------------------------------------------
// hamming_secded_dec_if
// Stream bundle for the SEC-DED decoder.
//   Input side : in_valid / in_ready handshake carrying code_in (CW bits).
//   Output side: out_valid / out_ready handshake carrying data_out (K bits)
//                plus the corr / dbl / err_pos error status.
//   Statistics : cnt_clr request and the corr_cnt / dbl_cnt counters.
// Modports:
//   master - the upstream source and downstream consumer, i.e. whoever
//            talks to the decoder.
//   slave  - the decoder itself.
// ---------------------------------------------------------------------------
interface hamming_secded_dec_if #(
    parameter int R     = 3,
    parameter int CNT_W = 16
);
    localparam int CW = 1 << R;
    localparam int K  = CW - 1 - R;

    logic             in_valid;
    logic             in_ready;
    logic [CW-1:0]    code_in;
    logic             out_valid;
    logic             out_ready;
    logic [K-1:0]     data_out;
    logic             corr;
    logic             dbl;
    logic [R-1:0]     err_pos;
    logic             cnt_clr;
    logic [CNT_W-1:0] corr_cnt;
    logic [CNT_W-1:0] dbl_cnt;

    modport master (
        output in_valid, code_in, out_ready, cnt_clr,
        input  in_ready, out_valid, data_out, corr, dbl, err_pos,
               corr_cnt, dbl_cnt
    );

    modport slave (
        input  in_valid, code_in, out_ready, cnt_clr,
        output in_ready, out_valid, data_out, corr, dbl, err_pos,
               corr_cnt, dbl_cnt
    );
endinterface

// File: rtl/hamming_secded_dec.sv
// ---------------------------------------------------------------------------
// hamming_secded_dec
// Two-stage pipelined extended-Hamming SEC-DED decoder for 2^R-bit
// codewords (bit 0 = overall even parity, bits 1..N = Hamming positions).
// Ports:
//   clock  - rising-edge clock
//   reset  - synchronous, active-high; clears the pipeline and counters
//   bus    - hamming_secded_dec_if.slave: input stream (in_valid/in_ready/
//            code_in), output stream (out_valid/out_ready/data_out/corr/
//            dbl/err_pos) and error statistics (cnt_clr/corr_cnt/dbl_cnt)
// Optional feature: define HAM_ERR_CNT_EN to build saturating error
// counters; otherwise corr_cnt/dbl_cnt read as zero and cnt_clr is ignored.
// ---------------------------------------------------------------------------
module hamming_secded_dec #(
    parameter int R     = 3,
    parameter int CNT_W = 16
) (
    input logic               clock,
    input logic               reset,
    hamming_secded_dec_if.slave bus
);
    localparam int CW = 1 << R;
    localparam int K  = CW - 1 - R;

    // XOR of the indices of all set Hamming positions.
    function automatic logic [R-1:0] syndrome(input logic [CW-1:0] c);
        logic [R-1:0]  s;
        logic [CW-1:0] sh;
        s = '0;
        for (int i = 1; i < CW; i++) begin
            sh = c >> i;
            if (sh[0]) s = s ^ R'(i);
        end
        return s;
    endfunction

    // Data bits are the non-power-of-two positions in ascending order.
    // Walking downwards and shifting left leaves the lowest position in bit 0.
    function automatic logic [K-1:0] extract(input logic [CW-1:0] c);
        logic [K-1:0]  d;
        logic [CW-1:0] sh;
        d = '0;
        for (int i = CW - 1; i >= 1; i--) begin
            if ((i & (i - 1)) != 0) begin
                sh = c >> i;
                d  = (d << 1) | K'(sh[0]);
            end
        end
        return d;
    endfunction

    logic advance;

    // Stage 1 : codeword, syndrome and overall parity
    logic          vld_p1_q;
    logic [CW-1:0] code_p1_q;
    logic [R-1:0]  syn_p1_q;
    logic          par_p1_q;

    // Stage 2 : corrected data and error classification
    logic          vld_p2_q;
    logic [K-1:0]  data_p2_q;
    logic          corr_p2_q;
    logic          dbl_p2_q;
    logic [R-1:0]  pos_p2_q;

    logic [CW-1:0] fixed_code;
    logic [K-1:0]  data_d;
    logic          corr_d;
    logic          dbl_d;
    logic [R-1:0]  pos_d;

    // Both stages move together; a full output stage that is not being
    // taken freezes the whole pipe, so in_ready mirrors the same condition.
    assign advance     = !vld_p2_q || bus.out_ready;
    assign bus.in_ready = advance;

    always_ff @(posedge clock) begin
        if (reset) begin
            vld_p1_q <= 1'b0;
        end else if (advance) begin
            vld_p1_q <= bus.in_valid;
        end
    end

    always_ff @(posedge clock) begin
        if (advance && bus.in_valid) begin
            code_p1_q <= bus.code_in;
            syn_p1_q  <= syndrome(bus.code_in);
            par_p1_q  <= ^bus.code_in;
        end
    end

    // Odd overall parity means a single flip: a non-zero syndrome names the
    // position, a zero syndrome means only the parity bit itself was hit.
    // Even parity with a non-zero syndrome is a double error; the data is
    // passed through uncorrected.
    always_comb begin
        fixed_code = code_p1_q;
        if (par_p1_q && (syn_p1_q != '0)) begin
            fixed_code[syn_p1_q] = ~code_p1_q[syn_p1_q];
        end
        data_d = extract(fixed_code);
        corr_d = par_p1_q;
        dbl_d  = !par_p1_q && (syn_p1_q != '0);
        pos_d  = syn_p1_q;
    end

    // Result registers only load on a real beat so bubbles leave the last
    // result (or the reset value) on the outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            vld_p2_q  <= 1'b0;
            data_p2_q <= '0;
            corr_p2_q <= 1'b0;
            dbl_p2_q  <= 1'b0;
            pos_p2_q  <= '0;
        end else if (advance) begin
            vld_p2_q <= vld_p1_q;
            if (vld_p1_q) begin
                data_p2_q <= data_d;
                corr_p2_q <= corr_d;
                dbl_p2_q  <= dbl_d;
                pos_p2_q  <= pos_d;
            end
        end
    end

    assign bus.out_valid = vld_p2_q;
    assign bus.data_out  = data_p2_q;
    assign bus.corr      = corr_p2_q;
    assign bus.dbl       = dbl_p2_q;
    assign bus.err_pos   = pos_p2_q;

`ifdef HAM_ERR_CNT_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + 1'b1;
    endfunction

    logic             out_fire;
    logic [CNT_W-1:0] corr_cnt_q;
    logic [CNT_W-1:0] dbl_cnt_q;

    assign out_fire = vld_p2_q && bus.out_ready;

    // Clear has priority over a same-cycle increment.
    always_ff @(posedge clock) begin
        if (reset || bus.cnt_clr) begin
            corr_cnt_q <= '0;
            dbl_cnt_q  <= '0;
        end else if (out_fire) begin
            if (corr_p2_q) corr_cnt_q <= sat_inc(corr_cnt_q);
            if (dbl_p2_q)  dbl_cnt_q  <= sat_inc(dbl_cnt_q);
        end
    end

    assign bus.corr_cnt = corr_cnt_q;
    assign bus.dbl_cnt  = dbl_cnt_q;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = bus.cnt_clr;
    assign bus.corr_cnt   = {CNT_W{1'b0}};
    assign bus.dbl_cnt    = {CNT_W{1'b0}};
`endif

endmodule

// File: doc/hamming_secded_dec.md
Name: hamming_secded_dec

Overview:
Parametrised, pipelined Hamming SEC-DED decoder. It is the successor of the fixed (7,4) single-error corrector, generalised to any 2^R-bit extended Hamming codeword. Adds an overall-parity bit for double-error detection, a valid/ready stream handshake with backpressure, and optional error statistics counters. It sits between a channel/storage read port and the consumer of the recovered data words.

Parameters:
R, 3, number of Hamming parity bits; legal range 2..6. Derived values: N = 2^R - 1, codeword width CW = N + 1 = 2^R, data width K = N - R (default CW=8, K=4).
CNT_W, 16, width of the error counters; used only with the optional feature.

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  codeword on code_in is valid
in_ready  out  1  block can accept a codeword this cycle
code_in  in  CW  codeword; bit 0 is overall parity, bit i (1..N) is Hamming position i
out_valid  out  1  decoded result valid
out_ready  in  1  consumer accepts the result
data_out  out  K  corrected data bits
corr  out  1  single error detected and corrected
dbl  out  1  double error detected; data uncorrectable
err_pos  out  R  syndrome, i.e. the corrected position (0 if none or if bit 0 was hit)
cnt_clr  in  1  synchronous clear of the error counters
corr_cnt  out  CNT_W  count of accepted beats with corr=1
dbl_cnt  out  CNT_W  count of accepted beats with dbl=1

Behaviour:
- Bit layout: positions that are powers of two (1,2,4,...) are parity. Data bits are the remaining positions in ascending order: data_out[0] is position 3, [1] is position 5, [2] is position 6, [3] is position 7, and so on.
- Syndrome s = XOR of indices i (1..N) where code_in[i]=1. Overall check q = XOR of code_in[CW-1:0]; the encoder produces even parity.
- Classification:
  - s=0, q=0: clean; corr=0, dbl=0.
  - s!=0, q=1: invert position s; corr=1, err_pos=s.
  - s=0, q=1: bit 0 flipped; data unaffected; corr=1, err_pos=0.
  - s!=0, q=0: dbl=1, corr=0, err_pos=s; data_out is the uncorrected extraction.
- Pipeline: 2 register stages. Stage 1 captures the codeword plus s and q. Stage 2 captures data_out, corr, dbl and err_pos. There are no combinational paths from code_in to the outputs.
- Latency: a beat accepted in cycle t appears on out_valid in cycle t+2 when there is no backpressure. Throughput is 1 beat per cycle.
- Stall rule: advance = !out_valid | out_ready, and in_ready = advance.
  - When advance=0, both stages hold.
  - While out_valid=1 and out_ready=0, all outputs stay stable.
  - Stage bubbles propagate as invalid entries; no beat is lost or duplicated.
- Handshake: a transfer occurs only on in_valid&in_ready (input side) or out_valid&out_ready (output side). in_valid may deassert at any time without side effects.
- Reset: both stage valids clear. After reset, out_valid=0, data_out=0, corr=0, dbl=0, err_pos=0, counters=0, and in_ready=1 in the cycle after reset deasserts. A reset mid-stream discards in-flight beats.
- Three or more bit errors are undefined; the block may miscorrect. This is not checked.

Optional Feature:
Macro HAM_ERR_CNT_EN.
- Defined: corr_cnt increments when an output beat is accepted with corr=1; dbl_cnt increments when one is accepted with dbl=1. Both saturate at 2^CNT_W-1, with no wrap. cnt_clr zeroes both next cycle, and clear wins over a simultaneous increment. Counters do not move while the output is stalled.
- Undefined: ports remain, corr_cnt and dbl_cnt are tied to 0, cnt_clr is ignored, and no counter flops are synthesised.

Test Plan:
- R=3; send 8'hAA (data 4'b1011) with out_ready=1 -> 2 cycles later out_valid=1, data_out=4'b1011, corr=0, dbl=0, err_pos=0.
- Send 8'h8A (bit 5 flipped) -> data_out=4'b1011, corr=1, err_pos=5. Send 8'hAB (bit 0 flipped) -> data_out=4'b1011, corr=1, err_pos=0.
- Send 8'hAC (bits 1 and 2 flipped) -> dbl=1, corr=0, err_pos=3, data_out=4'b1011.
- Stream 8'hAA, 8'h8A, 8'hAC back-to-back; hold out_ready=0 for 3 cycles while the first result is valid -> in_ready=0, outputs stable, all 3 results then delivered in order with none lost.
- Assert reset with 2 beats in flight -> out_valid=0 next cycle, no stale beat afterwards, counters=0.
- With HAM_ERR_CNT_EN, CNT_W=2: send 5 single-error beats -> corr_cnt stops at 3. Assert cnt_clr on the same cycle as an accepted corr beat -> corr_cnt=0.
